toggle_decoder: RTL and testbench

TOGGLE_DECODER -- requirements
Module: toggle_decoder

---
 rtl/toggle_dec_pkg.sv | 17 +
 rtl/toggle_decoder_if.sv | 24 ++
 rtl/toggle_sync.sv | 22 ++
 rtl/toggle_decoder.sv | 115 +++++++++++
 tb/tb_toggle_decoder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_dec_pkg.sv
// Shared types and constants for the toggle-encoded event decoder.
package toggle_dec_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 16;

    // Idle timer only has to reach TIMEOUT-1.
    function automatic int tmr_w(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/toggle_decoder_if.sv
// Line-side and status signals of the toggle decoder, grouped with modports.
interface toggle_decoder_if
    import toggle_dec_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             tin;
    logic             clr;
    logic             pulse;
    logic [CNT_W-1:0] count;
    logic             active;
    logic             timeout;
    logic             overflow;

    modport master (
        output tin, clr,
        input  pulse, count, active, timeout, overflow
    );

    modport slave (
        input  tin, clr,
        output pulse, count, active, timeout, overflow
    );
endinterface

// File: rtl/toggle_sync.sv
// Two-flop falling-edge synchronizer for the asynchronous toggle line.
module toggle_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    logic sync_p0;
    logic sync_p1;

    always_ff @(negedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    assign dout = sync_p1;
endmodule

// File: rtl/toggle_decoder.sv
// Toggle-line event decoder: strobe, saturating count, activity FSM with idle timeout.
// Define TOGGLE_DECODER_SYNC_EN to put a two-flop synchronizer in front of tin.
module toggle_decoder
    import toggle_dec_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic             clk,
    input logic             reset,
    toggle_decoder_if.slave bus
);
    localparam int               TW       = tmr_w(TIMEOUT);
    localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             tin_s;
    logic             t_prev;
    logic             evt;
    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_nxt;
    logic             tmo_nxt;
    logic             pulse_q;
    logic [CNT_W-1:0] count_q;
    logic             active_q;
    logic             timeout_q;
    logic             ovf_q;

`ifdef TOGGLE_DECODER_SYNC_EN
    toggle_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.tin),
        .dout  (tin_s)
    );
`else
    assign tin_s = bus.tin;
`endif

    assign evt = tin_s ^ t_prev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(negedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An event on the final timer count keeps the line ACTIVE.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        tmo_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (evt) begin
                    state_nxt = ACTIVE;
                    timer_nxt = '0;
                end
            end
            ACTIVE: begin
                if (evt) begin
                    timer_nxt = '0;
                end else if (timer == TMR_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    tmo_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            t_prev    <= 1'b0;
            pulse_q   <= 1'b0;
            timer     <= '0;
            active_q  <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            t_prev    <= tin_s;
            pulse_q   <= evt;
            timer     <= timer_nxt;
            active_q  <= (state_nxt == ACTIVE);
            timeout_q <= tmo_nxt;
            // clr wins over saturation, but a coincident event still counts.
            if (bus.clr) begin
                count_q <= evt ? CNT_W'(1) : '0;
                ovf_q   <= 1'b0;
            end else if (evt) begin
                if (count_q == CNT_MAX) begin
                    ovf_q <= 1'b1;
                end
                count_q <= sat_inc(count_q);
            end
        end
    end

    assign bus.pulse    = pulse_q;
    assign bus.count    = count_q;
    assign bus.active   = active_q;
    assign bus.timeout  = timeout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_toggle_decoder.sv
// Scoreboard bench for toggle_decoder: two instances (CNT_W=8 and CNT_W=3) share one stimulus stream.
module tb_toggle_decoder;
    localparam int TMO = 16;

`ifdef TOGGLE_DECODER_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    typedef struct {
        bit pulse;
        int count;
        bit active;
        bit timeout;
        bit ovf;
    } exp_t;

    typedef struct {
        bit       prev;
        bit [1:0] dly;
        int       cnt;
        bit       ovf;
        bit       act;
        int       quiet;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tin = 1'b0;
    logic clr = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t   q8[$];
    exp_t   q3[$];
    model_t m8 = '{default: 0};
    model_t m3 = '{default: 0};

    toggle_decoder_if #(.CNT_W(8)) if8 ();
    toggle_decoder_if #(.CNT_W(3)) if3 ();

    assign if8.tin = tin;
    assign if8.clr = clr;
    assign if3.tin = tin;
    assign if3.clr = clr;

    toggle_decoder #(.CNT_W(8), .TIMEOUT(TMO)) dut8 (
        .clk   (clk),
        .reset (rst),
        .bus   (if8)
    );

    toggle_decoder #(.CNT_W(3), .TIMEOUT(TMO)) dut3 (
        .clk   (clk),
        .reset (rst),
        .bus   (if3)
    );

    always #5 clk = ~clk;

    // Reference: events are level changes of the (optionally 2-edge delayed) line,
    // activity ends after TMO consecutive quiet edges.
    function automatic exp_t model_step(inout model_t m, input bit r, input bit t,
                                        input bit c, input int maxc);
        exp_t e;
        bit   ts;
        bit   ev;
        e = '{default: 0};
        if (r) begin
            m = '{default: 0};
            return e;
        end
        if (SYNC) begin
            ts    = m.dly[1];
            m.dly = {m.dly[0], t};
        end else begin
            ts = t;
        end
        ev     = (ts != m.prev);
        m.prev = ts;
        if (c) begin
            m.cnt = ev ? 1 : 0;
            m.ovf = 1'b0;
        end else if (ev) begin
            if (m.cnt >= maxc) m.ovf = 1'b1;
            else m.cnt = m.cnt + 1;
        end
        if (ev) begin
            m.act   = 1'b1;
            m.quiet = 0;
        end else if (m.act) begin
            m.quiet = m.quiet + 1;
            if (m.quiet == TMO) begin
                m.act     = 1'b0;
                m.quiet   = 0;
                e.timeout = 1'b1;
            end
        end
        e.pulse  = ev;
        e.count  = m.cnt;
        e.active = m.act;
        e.ovf    = m.ovf;
        return e;
    endfunction

    function automatic void cmp(input string name, input int act, input int exp, input int cyc);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    int cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        cyc++;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            cmp("w8.pulse",    int'(if8.pulse),    int'(e.pulse),   cyc);
            cmp("w8.count",    int'(if8.count),    e.count,         cyc);
            cmp("w8.active",   int'(if8.active),   int'(e.active),  cyc);
            cmp("w8.timeout",  int'(if8.timeout),  int'(e.timeout), cyc);
            cmp("w8.overflow", int'(if8.overflow), int'(e.ovf),     cyc);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            cmp("w3.pulse",    int'(if3.pulse),    int'(e.pulse),   cyc);
            cmp("w3.count",    int'(if3.count),    e.count,         cyc);
            cmp("w3.active",   int'(if3.active),   int'(e.active),  cyc);
            cmp("w3.timeout",  int'(if3.timeout),  int'(e.timeout), cyc);
            cmp("w3.overflow", int'(if3.overflow), int'(e.ovf),     cyc);
        end
    end

    task automatic step(input bit r, input bit t, input bit c);
        @(posedge clk);
        rst = r;
        tin = t;
        clr = c;
        q8.push_back(model_step(m8, r, t, c, 255));
        q3.push_back(model_step(m3, r, t, c, 7));
    endtask

    task automatic toggle(input bit c);
        step(1'b0, ~tin, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, tin, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with tin low, then quiet.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(3);

        // Five toggles two edges apart.
        for (int i = 0; i < 5; i++) begin
            toggle(1'b0);
            idle(1);
        end

        // Four back-to-back toggles, then a full quiet period.
        for (int i = 0; i < 4; i++) toggle(1'b0);
        idle(TMO + 4);

        // Event landing on the final timer count, then a real timeout.
        toggle(1'b0);
        idle(TMO - 1);
        toggle(1'b0);
        idle(TMO + 3);

        // Saturation and clr coincident with a toggle.
        step(1'b1, tin, 1'b0);
        for (int i = 0; i < 9; i++) toggle(1'b0);
        idle(2);
        toggle(1'b1);
        idle(3);
        step(1'b0, tin, 1'b1);
        idle(2);

        // Reset in the middle of a burst.
        for (int i = 0; i < 3; i++) toggle(1'b0);
        step(1'b1, ~tin, 1'b0);
        idle(4);

        // tin already high when reset releases.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(5);

        // Randomized traffic with occasional quiet stretches, clr and reset.
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 50) idle(TMO + 2);
            step($urandom_range(0, 99) < 2, ($urandom_range(0, 2) == 0) ? ~tin : tin,
                 $urandom_range(0, 29) == 0);
        end
        idle(4);

        repeat (4) @(posedge clk);
        checks++;
        if (q8.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q8.size(), q3.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
